// File: rtl/conv_out_serializer.sv
// Buffers wide convolution result vectors in a small FIFO and re-emits each one
// as a sequence of narrow LANE_NUM-channel beats over a valid/ready handshake.
module conv_out_serializer #(
    parameter int unsigned CONV_OUT_NUM = 18,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned LANE_NUM     = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned BEAT_NUM     = CONV_OUT_NUM / LANE_NUM
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0]   Conv_data_in,
    input  logic                                 Conv_data_valid_in,
    output logic [LANE_NUM*DATA_WIDTH-1:0]       ser_data_out,
    output logic                                 ser_valid_out,
    input  logic                                 ser_ready_in,
    output logic                                 ser_last_out,
    output logic [$clog2(CONV_OUT_NUM)-1:0]      ser_ch_idx_out,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level_out,
    output logic                                 almost_full_out,
    output logic                                 overflow_out
);

    localparam int unsigned VecW  = CONV_OUT_NUM * DATA_WIDTH;
    localparam int unsigned BeatW = LANE_NUM * DATA_WIDTH;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned CntW  = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
    localparam int unsigned IdxW  = $clog2(CONV_OUT_NUM);

    localparam logic [LvlW-1:0] DepthLvl  = LvlW'(FIFO_DEPTH);
    localparam logic [LvlW-1:0] AfThresh  = LvlW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] LastBeat  = CntW'(BEAT_NUM - 1);
    localparam logic [IdxW-1:0] LaneStep  = IdxW'(LANE_NUM);

    logic [VecW-1:0] mem_q [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [CntW-1:0] beat_q, beat_d;
    logic            overflow_q, overflow_d;

    logic            valid;
    logic            last;
    logic            hs;
    logic            pop;
    logic            push;

    // Head entry viewed as an array of beats; lane 0 of beat 0 sits in the LSBs.
    logic [BEAT_NUM-1:0][BeatW-1:0] head_beats;

    assign head_beats = mem_q[rd_ptr_q];
    assign valid      = (level_q != '0);
    assign last       = valid & (beat_q == LastBeat);

    assign ser_data_out    = head_beats[beat_q];
    assign ser_valid_out   = valid;
    assign ser_last_out    = last;
    assign ser_ch_idx_out  = IdxW'(beat_q) * LaneStep;
    assign fifo_level_out  = level_q;
    assign almost_full_out = (level_q >= AfThresh);
    assign overflow_out    = overflow_q;

    always_comb begin
        hs   = valid & ser_ready_in;
        pop  = hs & last;
        // A full FIFO still accepts a vector in the cycle its head is popped.
        push = Conv_data_valid_in & ((level_q < DepthLvl) | pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        beat_d     = beat_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        if (hs) begin
            beat_d = last ? '0 : beat_q + CntW'(1);
        end

        if (Conv_data_valid_in && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; only the pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= Conv_data_in;
        end
    end

`ifndef SYNTHESIS
    a_level_bound : assert property (@(posedge clk) disable iff (rst)
        level_q <= DepthLvl);

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (valid && !ser_ready_in) |=>
            (valid && $stable(ser_data_out) && $stable(ser_last_out)
             && $stable(ser_ch_idx_out)));
`endif

endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed self-checking bench for conv_out_serializer with default parameters
// (18 channels x 8 bits, 2 lanes, 9 beats per vector, 4-entry FIFO).
module tb_conv_out_serializer;

    localparam int unsigned VecW = 18 * 8;

    logic            clk;
    logic            rst;
    logic [VecW-1:0] conv_data;
    logic            conv_valid;
    logic [15:0]     ser_data;
    logic            ser_valid;
    logic            ser_ready;
    logic            ser_last;
    logic [4:0]      ser_ch_idx;
    logic [2:0]      fifo_level;
    logic            almost_full;
    logic            overflow;

    int errors = 0;
    int checks = 0;

    conv_out_serializer dut (
        .clk                (clk),
        .rst                (rst),
        .Conv_data_in       (conv_data),
        .Conv_data_valid_in (conv_valid),
        .ser_data_out       (ser_data),
        .ser_valid_out      (ser_valid),
        .ser_ready_in       (ser_ready),
        .ser_last_out       (ser_last),
        .ser_ch_idx_out     (ser_ch_idx),
        .fifo_level_out     (fifo_level),
        .almost_full_out    (almost_full),
        .overflow_out       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel k of the vector carries base + k.
    function automatic logic [VecW-1:0] mk_vec(input logic [7:0] base);
        logic [VecW-1:0] v;
        v = '0;
        for (int k = 0; k < 18; k++) begin
            v[k*8 +: 8] = base + 8'(k);
        end
        return v;
    endfunction

    // Beat b of a vector built by mk_vec: {channel 2b+1, channel 2b}.
    function automatic logic [15:0] exp_beat(input logic [7:0] base, input int b);
        logic [7:0] lo;
        lo = base + 8'(2 * b);
        return {lo + 8'd1, lo};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        conv_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push_vec(input logic [7:0] base);
        conv_data  = mk_vec(base);
        conv_valid = 1'b1;
        step();
        conv_valid = 1'b0;
    endtask

    task automatic test_reset();
        ser_ready = 1'b1;
        do_reset();
        checks++;
        if (ser_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", ser_valid);
        end
        checks++;
        if (ser_last !== 1'b0) begin
            errors++; $display("FAIL reset_last: got %b expected 0", ser_last);
        end
        checks++;
        if (ser_ch_idx !== 5'd0) begin
            errors++; $display("FAIL reset_idx: got %0d expected 0", ser_ch_idx);
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
        end
        checks++;
        if (almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_af: got %b expected 0", almost_full);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: got %b expected 0", overflow);
        end
    endtask

    task automatic test_single();
        ser_ready = 1'b1;
        push_vec(8'h00);
        checks++;
        if (ser_data !== 16'h0100) begin
            errors++; $display("FAIL single_beat0: got %h expected 0100", ser_data);
        end
        for (int b = 0; b < 9; b++) begin
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== exp_beat(8'h00, b)
                || ser_ch_idx !== 5'(2 * b) || ser_last !== (b == 8)) begin
                errors++;
                $display("FAIL single_beat%0d: got v=%b d=%h idx=%0d last=%b expected v=1 d=%h idx=%0d last=%b",
                         b, ser_valid, ser_data, ser_ch_idx, ser_last, exp_beat(8'h00, b),
                         2 * b, (b == 8));
            end
            if (b == 8) begin
                checks++;
                if (ser_data !== 16'h1110) begin
                    errors++; $display("FAIL single_beat8: got %h expected 1110", ser_data);
                end
            end
            step();
        end
        checks++;
        if (ser_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL single_drain: got v=%b level=%0d expected v=0 level=0",
                     ser_valid, fifo_level);
        end
    endtask

    task automatic test_ready_toggle();
        int b;
        b = 0;
        ser_ready = 1'b0;
        push_vec(8'h20);
        for (int i = 0; i < 40 && b < 9; i++) begin
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== exp_beat(8'h20, b)
                || ser_ch_idx !== 5'(2 * b) || ser_last !== (b == 8)) begin
                errors++;
                $display("FAIL toggle_cyc%0d: got v=%b d=%h idx=%0d expected v=1 d=%h idx=%0d",
                         i, ser_valid, ser_data, ser_ch_idx, exp_beat(8'h20, b), 2 * b);
            end
            ser_ready = (i % 3 == 0);
            step();
            if (ser_ready) b++;
        end
        ser_ready = 1'b1;
        checks++;
        if (b !== 9 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL toggle_done: got beats=%0d v=%b expected beats=9 v=0", b, ser_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bases [5];
        bases = '{8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0};
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_vec(bases[i]);
            checks++;
            if (fifo_level !== 3'((i < 4) ? i + 1 : 4) || almost_full !== (i >= 2)
                || overflow !== (i == 4)) begin
                errors++;
                $display("FAIL ovf_push%0d: got level=%0d af=%b ovf=%b expected level=%0d af=%b ovf=%b",
                         i, fifo_level, almost_full, overflow, (i < 4) ? i + 1 : 4,
                         (i >= 2), (i == 4));
            end
        end
        ser_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            for (int b = 0; b < 9; b++) begin
                checks++;
                if (ser_valid !== 1'b1 || ser_data !== exp_beat(bases[v], b)) begin
                    errors++;
                    $display("FAIL ovf_drain_v%0d_b%0d: got v=%b d=%h expected v=1 d=%h",
                             v, b, ser_valid, ser_data, exp_beat(bases[v], b));
                end
                step();
            end
        end
        checks++;
        if (ser_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: got v=%b ovf=%b expected v=0 ovf=1", ser_valid, overflow);
        end
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] bases [5];
        bases = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90};
        do_reset();
        ser_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_vec(bases[i]);
        ser_ready = 1'b1;
        for (int b = 0; b < 8; b++) step();
        checks++;
        if (ser_last !== 1'b1 || fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL fpp_pre: got last=%b level=%0d expected last=1 level=4",
                     ser_last, fifo_level);
        end
        push_vec(bases[4]);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_post: got level=%0d ovf=%b expected level=4 ovf=0",
                     fifo_level, overflow);
        end
        for (int v = 1; v < 5; v++) begin
            for (int b = 0; b < 9; b++) begin
                checks++;
                if (ser_valid !== 1'b1 || ser_data !== exp_beat(bases[v], b)) begin
                    errors++;
                    $display("FAIL fpp_v%0d_b%0d: got v=%b d=%h expected v=1 d=%h",
                             v, b, ser_valid, ser_data, exp_beat(bases[v], b));
                end
                step();
            end
        end
        checks++;
        if (ser_valid !== 1'b0) begin
            errors++; $display("FAIL fpp_empty: got v=%b expected 0", ser_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bases [4];
        bases = '{8'h05, 8'h25, 8'h45, 8'h65};
        do_reset();
        ser_ready = 1'b1;
        for (int t = 0; t <= 37; t++) begin
            if (t >= 1 && t <= 36) begin
                checks++;
                if (ser_valid !== 1'b1 || ser_data !== exp_beat(bases[(t-1)/9], (t-1) % 9)
                    || fifo_level > 3'd1) begin
                    errors++;
                    $display("FAIL b2b_t%0d: got v=%b d=%h level=%0d expected v=1 d=%h level<=1",
                             t, ser_valid, ser_data, fifo_level,
                             exp_beat(bases[(t-1)/9], (t-1) % 9));
                end
            end else if (t == 37) begin
                checks++;
                if (ser_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_end: got v=%b expected 0", ser_valid);
                end
            end
            if (t % 9 == 0 && t < 36) begin
                conv_data  = mk_vec(bases[t/9]);
                conv_valid = 1'b1;
            end else begin
                conv_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ser_ready = 1'b0;
        push_vec(8'h33);
        push_vec(8'h55);
        ser_ready = 1'b1;
        for (int b = 0; b < 4; b++) step();
        checks++;
        if (ser_ch_idx !== 5'd8 || fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL rmid_pre: got idx=%0d level=%0d expected idx=8 level=2",
                     ser_ch_idx, fifo_level);
        end
        rst        = 1'b1;
        conv_data  = mk_vec(8'h77);
        conv_valid = 1'b1;
        step();
        rst        = 1'b0;
        conv_valid = 1'b0;
        checks++;
        if (ser_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0
            || ser_ch_idx !== 5'd0 || ser_last !== 1'b0) begin
            errors++;
            $display("FAIL rmid_post: got v=%b level=%0d ovf=%b idx=%0d last=%b expected 0 0 0 0 0",
                     ser_valid, fifo_level, overflow, ser_ch_idx, ser_last);
        end
        push_vec(8'hE0);
        checks++;
        if (ser_valid !== 1'b1 || ser_ch_idx !== 5'd0 || ser_data !== 16'hE1E0
            || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL rmid_restart: got v=%b idx=%0d d=%h level=%0d expected v=1 idx=0 d=e1e0 level=1",
                     ser_valid, ser_ch_idx, ser_data, fifo_level);
        end
        for (int b = 0; b < 9; b++) step();
        checks++;
        if (ser_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_drain: got v=%b expected 0", ser_valid);
        end
    endtask

    initial begin
        rst        = 1'b1;
        conv_valid = 1'b0;
        conv_data  = '0;
        ser_ready  = 1'b0;
        step();
        test_reset();
        test_single();
        test_ready_toggle();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_out_serializer.md
# conv_out_serializer

Output-side transmitter for the convolution unit. It accepts the wide, unthrottled `CONV_OUT_NUM`-channel result vector that the NPU core emits with a single valid strobe and buffers whole vectors in a small FIFO. It then re-emits each vector as a sequence of narrow `LANE_NUM`-channel beats over a valid/ready handshake toward the feature-map write-back path. It is the counterpart of the window pre-processor: that block turns a narrow stream into wide windows, and this block turns wide results back into a narrow stream.

## Interface
Parameters:
- `CONV_OUT_NUM`, 18, channels per result vector
- `DATA_WIDTH`, 8, bits per channel
- `LANE_NUM`, 2, channels per output beat; `CONV_OUT_NUM % LANE_NUM == 0`
- `FIFO_DEPTH`, 4, vector entries; power of two, ≥2
- `BEAT_NUM`, `CONV_OUT_NUM/LANE_NUM` (9), beats per vector (derived)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `Conv_data_in`  in  `CONV_OUT_NUM*DATA_WIDTH`  result vector; channel k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`
- `Conv_data_valid_in`  in  1  one-cycle strobe per vector; no backpressure toward the source
- `ser_data_out`  out  `LANE_NUM*DATA_WIDTH`  beat; lane j carries channel `beat*LANE_NUM+j`, lane 0 in the LSBs
- `ser_valid_out`  out  1  beat valid
- `ser_ready_in`  in  1  sink ready
- `ser_last_out`  out  1  high on the final beat of a vector (`beat == BEAT_NUM-1`)
- `ser_ch_idx_out`  out  `$clog2(CONV_OUT_NUM)`  channel index of lane 0 in the current beat
- `fifo_level_out`  out  `$clog2(FIFO_DEPTH)+1`  number of stored vectors
- `almost_full_out`  out  1  `fifo_level_out >= FIFO_DEPTH-1`; used by the control FSM to stall the input stream
- `overflow_out`  out  1  sticky; a vector was dropped

## Operation
FIFO:
- Register array of `FIFO_DEPTH` entries, each `CONV_OUT_NUM*DATA_WIDTH` wide.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- `pop` = `ser_valid_out & ser_ready_in & ser_last_out`.
- `push` = `Conv_data_valid_in & (level < FIFO_DEPTH | pop)`. A write into a full FIFO is accepted in the same cycle as a pop.
- Level update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `Conv_data_valid_in` with the FIFO full and no pop: the vector is discarded, `overflow_out` is set to 1, and no FIFO state changes.
- `overflow_out` is cleared only by `rst`.

Serializer:
- Beat counter `beat` runs 0..`BEAT_NUM-1`.
- `ser_valid_out = (level != 0)`.
- `ser_data_out` is the combinational slice `beat*LANE_NUM*DATA_WIDTH` of the head entry.
- `ser_ch_idx_out = beat*LANE_NUM`.
- On a handshake (`valid & ready`): if `beat == BEAT_NUM-1`, `beat` returns to 0 and the head entry is popped; otherwise `beat` increments.
- While `valid & !ready`, all of `ser_data_out`, `ser_last_out` and `ser_ch_idx_out` are held stable.
- `ser_valid_out` never drops without a handshake.

Reset (`rst`, checked at the clock edge):
- Pointers, level, `beat` and `overflow_out` clear to 0.
- Resulting outputs: `ser_valid_out=0`, `ser_last_out=0`, `ser_ch_idx_out=0`, `fifo_level_out=0`, `almost_full_out=0`, `overflow_out=0`. `ser_data_out` is don't-care (FIFO memory is not cleared).
- Reset asserted mid-vector abandons the partial vector and all queued vectors.
- An input strobe coincident with `rst` is ignored.

## Timing
- A vector pushed at edge N is visible at the head from cycle N+1. If the FIFO was empty, `ser_valid_out=1` with beat 0 in cycle N+1.
- Throughput with `ser_ready_in` held at 1: one beat per cycle. Consecutive vectors stream with no bubble, because the last beat of one vector and beat 0 of the next are adjacent cycles.
- Sustained input rate that avoids overflow with ready=1: one vector per `BEAT_NUM` cycles.
- Outputs derived from pop or level (`fifo_level_out`, `almost_full_out`) update one cycle after the causing edge. They are registered state with no combinational path from `ser_ready_in`.
- The only combinational paths are from `ser_ready_in` into next-state logic. There is no input→output combinational path.

## Test plan
- Single vector, channels valued 0x00..0x11, ready=1 → 9 beats in cycles N+1..N+9. Beat 0 is `ser_data_out=0x0100`, beat 8 is `0x1110` with `ser_last_out=1`. `ser_ch_idx_out` steps 0,2,…,16. Level then returns to 0.
- Same vector with ready toggling 1,0,0,1… → each beat is held unchanged while ready=0, no beat is skipped or repeated, and all 9 beats are delivered.
- Five vectors with ready=0 → level=4 and `almost_full_out=1` after the third push; the 5th vector is dropped and `overflow_out=1`. Releasing ready then delivers exactly vectors 1–4 in order. The `overflow_out` flag persists until `rst`.
- FIFO full, input strobe in the same cycle as the handshake on `ser_last_out` → push accepted, level stays 4, `overflow_out` stays 0, and the new vector is emitted last.
- Four vectors spaced 9 cycles apart, ready=1 → 36 contiguous valid beats with no idle cycle and level never exceeding 1.
- `rst` asserted during beat 4 with 2 vectors queued → next cycle `ser_valid_out=0`, level=0, `overflow_out=0`. A following vector restarts cleanly at beat 0.
